// File: rtl/histo_frame_ctrl.sv
// histo_frame_ctrl
// ----------------
// Sequencer for a 1024-bin, 24-bit pixel histogram. It arms the histogram for
// accumulation over a programmable number of frames, then sweeps every bin out
// through a small skid FIFO onto a valid/ready stream. The stream ends with a
// 32-bit checksum trailer. The histogram is then cleared and re-armed.
//
// Parameters
//   RD_LAT      cycles from a hist_bin change to valid hist_data
//   FIFO_DEPTH  output skid FIFO depth (must be >= RD_LAT+1)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            run request, sampled only in IDLE and CLEAR
//   frames_per_histo  frames accumulated per packet (0 behaves as 1)
//   frame_valid       sensor frame envelope
//   hist_rw           1 = histogram accumulates, 0 = read mode
//   hist_bin          bin address in read mode
//   hist_data         bin count, RD_LAT cycles after hist_bin
//   hist_clr          one-cycle histogram clear pulse
//   out_valid/ready   stream handshake
//   out_data          zero-extended bin count, or the checksum trailer
//   out_last          marks the trailer word
//   busy              high whenever the sequencer is not idle
//   frames_dropped    saturating count of frames started during readout
//   packet_count      wrapping count of completed packets
module histo_frame_ctrl #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  frames_per_histo,
  input  logic        frame_valid,
  output logic        hist_rw,
  output logic [9:0]  hist_bin,
  input  logic [23:0] hist_data,
  output logic        hist_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] frames_dropped,
  output logic [15:0] packet_count
);

  localparam int              PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW          = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]      SETTLE_LAST = 8'(RD_LAT + 1);
  localparam logic [7:0]      DEPTH_W     = 8'(FIFO_DEPTH);
  localparam logic [PW-1:0]   PTR_LAST    = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_ACCUM,
    S_SETTLE,
    S_READ,
    S_TRAIL,
    S_CLEAR
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          fv_q;
  logic          fv_rise;
  logic          fv_fall;
  logic [7:0]    n_lat;
  logic [7:0]    n_eff;
  logic [7:0]    frame_cnt;
  logic [7:0]    settle_cnt;
  logic          settle_done;
  logic [10:0]   bin_cnt;
  logic [RD_LAT:0] rd_pipe;
  logic [7:0]    in_flight;
  logic [7:0]    outstanding;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   checksum;

  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          trailer_phase;
  logic          trailer_done;
  logic          drop_event;

  // Frame edges are taken against a registered copy, so a frame that is
  // already high when WAIT_SOF is entered produces no rising edge there.
  assign fv_rise = frame_valid & ~fv_q;
  assign fv_fall = ~frame_valid & fv_q;
  assign n_eff   = (frames_per_histo == 8'd0) ? 8'd1 : frames_per_histo;

  assign settle_done = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);

  // Reads issued but not yet landed in the FIFO.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      in_flight = in_flight + {7'd0, rd_pipe[i]};
    end
  end

  // A word popped this cycle frees its FIFO slot at the same edge, so it is
  // excluded here; this keeps the sweep at one word per cycle when unstalled.
  assign outstanding = in_flight + 8'(fifo_cnt) - {7'd0, pop};

  // Bin 0 is issued on the last SETTLE cycle so that the first word appears
  // RD_LAT+1 cycles after READ is entered.
  assign issue = settle_done ||
                 ((state == S_READ) && !bin_cnt[10] && (outstanding < DEPTH_W));

  assign push          = rd_pipe[RD_LAT];
  assign fifo_empty    = (fifo_cnt == '0);
  assign pop           = !fifo_empty && out_ready;
  assign trailer_phase = (state == S_TRAIL) && fifo_empty;
  assign trailer_done  = trailer_phase && out_ready;

  assign drop_event = fv_rise && ((state == S_SETTLE) || (state == S_READ) ||
                                  (state == S_TRAIL)  || (state == S_CLEAR));

  // The stream head is read straight from the FIFO; it only moves on a pop,
  // which keeps data/last stable while the sink stalls.
  assign out_valid = !fifo_empty || trailer_phase;
  assign out_last  = trailer_phase;
  assign out_data  = trailer_phase ? checksum :
                     (fifo_empty ? 32'd0 : {8'd0, fifo_mem[rd_ptr]});

  assign hist_rw  = (state == S_WAIT_SOF) || (state == S_ACCUM);
  assign hist_clr = (state == S_CLEAR);
  assign busy     = (state != S_IDLE);

  // Next-state logic. enable is looked at only in IDLE and CLEAR so that a
  // packet in progress always runs to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (enable) state_nxt = S_WAIT_SOF;
      S_WAIT_SOF: if (fv_rise) state_nxt = S_ACCUM;
      S_ACCUM:    if (fv_fall && (8'(frame_cnt + 8'd1) == n_lat)) state_nxt = S_SETTLE;
      S_SETTLE:   if (settle_done) state_nxt = S_READ;
      S_READ:     if (bin_cnt[10] && (rd_pipe == '0)) state_nxt = S_TRAIL;
      S_TRAIL:    if (trailer_done) state_nxt = S_CLEAR;
      S_CLEAR:    state_nxt = enable ? S_WAIT_SOF : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, frame counting and the read-issue pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fv_q       <= 1'b0;
      n_lat      <= 8'd1;
      frame_cnt  <= 8'd0;
      settle_cnt <= 8'd0;
      bin_cnt    <= 11'd0;
      hist_bin   <= 10'd0;
      rd_pipe    <= '0;
      checksum   <= 32'd0;
    end else begin
      state <= state_nxt;
      fv_q  <= frame_valid;

      if (((state == S_IDLE) && enable) || (state == S_CLEAR)) begin
        n_lat <= n_eff;
      end

      if (state == S_WAIT_SOF) begin
        frame_cnt <= 8'd0;
      end else if ((state == S_ACCUM) && fv_fall) begin
        frame_cnt <= frame_cnt + 8'd1;
      end

      if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
      end else begin
        settle_cnt <= 8'd0;
      end

      if (issue) begin
        hist_bin <= bin_cnt[9:0];
        bin_cnt  <= bin_cnt + 11'd1;
      end else if (state == S_SETTLE) begin
        bin_cnt  <= 11'd0;
      end

      rd_pipe <= {rd_pipe[RD_LAT-1:0], issue};

      if (state == S_SETTLE) begin
        checksum <= 32'd0;
      end else if (push) begin
        checksum <= checksum + {8'd0, hist_data};
      end
    end
  end

  // Skid FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

  // FIFO storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= hist_data;
    end
  end

  // Status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_dropped <= 16'd0;
      packet_count   <= 16'd0;
    end else begin
      if (drop_event && (frames_dropped != 16'hFFFF)) begin
        frames_dropped <= frames_dropped + 16'd1;
      end
      if (state == S_CLEAR) begin
        packet_count <= packet_count + 16'd1;
      end
    end
  end

endmodule
